// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller: a shift scoreboard of in-flight destinations
// resolves each ID source to a bypass select and stalls ID when a load result is too young.
module fwd_hazard_ctrl #(
  parameter int NUM_SRC   = 2,
  parameter int DEPTH     = 3,
  parameter int AW        = 5,
  parameter int LOAD_DIST = 2,
  parameter int CW        = 16,
  localparam int SW       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic [AW-1:0]         id_dst,
  input  logic [NUM_SRC*AW-1:0] id_src,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [NUM_SRC*SW-1:0] ex_fwd_sel,
  output logic [CW-1:0]         stall_count
);

  // Index k of each slot vector holds scoreboard slot k+1 (index 0 = instruction in EXE).
  logic [DEPTH-1:0]         slot_v_q, slot_v_d;
  logic [DEPTH-1:0]         slot_wr_q, slot_wr_d;
  logic [DEPTH-1:0]         slot_ld_q, slot_ld_d;
  logic [DEPTH-1:0][AW-1:0] slot_dst_q, slot_dst_d;

  logic [NUM_SRC-1:0][SW-1:0] sel_s;
  logic [NUM_SRC-1:0]         near_ld_s;
  logic                       hazard_s;
  logic                       stall_s;

  logic                  ex_valid_q, ex_valid_d;
  logic [NUM_SRC*SW-1:0] ex_sel_q, ex_sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Operand resolution: scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    sel_s     = '0;
    near_ld_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_v_q[k] && slot_wr_q[k] && (slot_dst_q[k] != '0) &&
            (slot_dst_q[k] == id_src[i*AW +: AW])) begin
          sel_s[i]     = SW'(k + 1);
          near_ld_s[i] = slot_ld_q[k] && ((k + 1) < LOAD_DIST);
        end else begin
          sel_s[i]     = sel_s[i];
          near_ld_s[i] = near_ld_s[i];
        end
      end
    end
    hazard_s = |near_ld_s;
    stall_s  = reset_n && id_valid && hazard_s && !flush;
  end

  // Next state: scoreboard always shifts; slot 1 and EXE take the ID instruction or a bubble.
  always_comb begin
    slot_v_d   = slot_v_q;
    slot_wr_d  = slot_wr_q;
    slot_ld_d  = slot_ld_q;
    slot_dst_d = slot_dst_q;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      slot_v_d[k]   = slot_v_q[k-1];
      slot_wr_d[k]  = slot_wr_q[k-1];
      slot_ld_d[k]  = slot_ld_q[k-1];
      slot_dst_d[k] = slot_dst_q[k-1];
    end
    slot_v_d[0]   = id_valid;
    slot_wr_d[0]  = id_reg_write;
    slot_ld_d[0]  = id_is_load;
    slot_dst_d[0] = id_dst;
    ex_valid_d    = id_valid;
    ex_sel_d      = id_valid ? sel_s : '0;
    cnt_d         = cnt_q;
    if (flush) begin
      slot_v_d   = '0;
      ex_valid_d = 1'b0;
      ex_sel_d   = '0;
    end else if (stall_s) begin
      slot_v_d[0] = 1'b0;
      ex_valid_d  = 1'b0;
      ex_sel_d    = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_v_q   <= '0;
      slot_wr_q  <= '0;
      slot_ld_q  <= '0;
      slot_dst_q <= '0;
      ex_valid_q <= 1'b0;
      ex_sel_q   <= '0;
      cnt_q      <= '0;
    end else begin
      slot_v_q   <= slot_v_d;
      slot_wr_q  <= slot_wr_d;
      slot_ld_q  <= slot_ld_d;
      slot_dst_q <= slot_dst_d;
      ex_valid_q <= ex_valid_d;
      ex_sel_q   <= ex_sel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign stall       = stall_s;
  assign ex_valid    = ex_valid_q;
  assign ex_fwd_sel  = ex_sel_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: per-cycle history model of issued instructions, directed
// scenarios with literal expectations, randomized traffic, and a deep/narrow-counter instance.
module tb_fwd_hazard_ctrl;
  localparam int DEPTH = 3;
  localparam int LD    = 2;
  localparam int MAXC  = 4200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, id_valid, id_reg_write, id_is_load;
  logic [4:0]  id_dst;
  logic [9:0]  id_src;
  logic        stall, ex_valid;
  logic [3:0]  ex_fwd_sel;
  logic [15:0] stall_count;

  logic        b_valid, b_wr, b_ld, b_flush;
  logic [4:0]  b_dst;
  logic [9:0]  b_src;
  logic        b_stall, b_ex_valid;
  logic [9:0]  b_sel;
  logic [3:0]  b_count;

  fwd_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_dst(id_dst),
    .id_src(id_src), .stall(stall), .ex_valid(ex_valid),
    .ex_fwd_sel(ex_fwd_sel), .stall_count(stall_count));

  fwd_hazard_ctrl #(.NUM_SRC(2), .DEPTH(20), .AW(5), .LOAD_DIST(20), .CW(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .flush(b_flush), .id_valid(b_valid),
    .id_reg_write(b_wr), .id_is_load(b_ld), .id_dst(b_dst),
    .id_src(b_src), .stall(b_stall), .ex_valid(b_ex_valid),
    .ex_fwd_sel(b_sel), .stall_count(b_count));

  int n_checks = 0;
  int n_fail   = 0;

  // History model: e_*[n] is what entered EXE at edge n; entries at or before epoch are dead.
  bit         e_v[MAXC];
  bit         e_wr[MAXC];
  bit         e_ld[MAXC];
  logic [4:0] e_dst[MAXC];
  int         cyc   = 0;
  int         epoch = 0;
  logic       m_ex_valid = 1'b0;
  logic [1:0] m_sel0 = 2'd0, m_sel1 = 2'd0;
  int         m_cnt = 0;
  logic       obs_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void lookup(input logic [4:0] src, output int sel, output bit is_ld);
    sel   = 0;
    is_ld = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      int n;
      n = cyc - k + 1;
      if (sel == 0 && n > epoch && e_v[n] && e_wr[n] && src != 5'd0 && e_dst[n] == src) begin
        sel   = k;
        is_ld = e_ld[n];
      end
    end
  endfunction

  function automatic void predict(output bit st, output logic [1:0] s0, output logic [1:0] s1);
    int a, b;
    bit la, lb;
    lookup(id_src[4:0], a, la);
    lookup(id_src[9:5], b, lb);
    st = !flush && id_valid && ((la && a < LD) || (lb && b < LD));
    s0 = 2'(a);
    s1 = 2'(b);
  endfunction

  task automatic model_edge();
    bit st;
    logic [1:0] s0, s1;
    predict(st, s0, s1);
    cyc++;
    if (flush) begin
      e_v[cyc] = 1'b0; epoch = cyc;
      m_ex_valid = 1'b0; m_sel0 = 2'd0; m_sel1 = 2'd0;
    end else if (st) begin
      e_v[cyc] = 1'b0;
      m_ex_valid = 1'b0; m_sel0 = 2'd0; m_sel1 = 2'd0;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      e_v[cyc] = id_valid; e_wr[cyc] = id_reg_write; e_ld[cyc] = id_is_load; e_dst[cyc] = id_dst;
      m_ex_valid = id_valid;
      m_sel0 = id_valid ? s0 : 2'd0;
      m_sel1 = id_valid ? s1 : 2'd0;
    end
  endtask

  task automatic model_reset();
    epoch = cyc;
    m_ex_valid = 1'b0; m_sel0 = 2'd0; m_sel1 = 2'd0; m_cnt = 0;
  endtask

  task automatic drive(input logic v, wr, ld, input logic [4:0] dst, s0, s1, input logic fl);
    id_valid = v; id_reg_write = wr; id_is_load = ld; id_dst = dst;
    id_src = {s1, s0}; flush = fl;
  endtask

  // One cycle: drive, compare everything against the model mid-cycle, advance the model.
  task automatic step(input logic v, wr, ld, input logic [4:0] dst, s0, s1, input logic fl);
    bit st;
    logic [1:0] p0, p1;
    drive(v, wr, ld, dst, s0, s1, fl);
    @(negedge clk);
    predict(st, p0, p1);
    obs_stall = stall;
    chk("stall", {31'd0, stall}, {31'd0, st});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex_valid});
    chk("ex_fwd_sel", {28'd0, ex_fwd_sel}, {28'd0, m_sel1, m_sel0});
    chk("stall_count", {16'd0, stall_count}, m_cnt);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int nst;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    b_valid = 1'b0; b_wr = 1'b0; b_ld = 1'b0; b_flush = 1'b0; b_dst = 5'd0; b_src = 10'd0;
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_sel", {28'd0, ex_fwd_sel}, 32'd0);
    chk("rst_count", {16'd0, stall_count}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // ALU pair
    step(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0);
    chk("alu_nostall0", {31'd0, obs_stall}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd4, 1'b0);
    chk("alu_nostall1", {31'd0, obs_stall}, 32'd0);
    chk("alu_sel", {28'd0, ex_fwd_sel}, 32'h1);

    // Load-use
    step(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 1'b0);
    chk("lu_stall", {31'd0, obs_stall}, 32'd1);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 1'b0);
    chk("lu_stall_clear", {31'd0, obs_stall}, 32'd0);
    chk("lu_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_sel", {28'd0, ex_fwd_sel}, 32'h2);
    chk("lu_count", {16'd0, stall_count}, 32'd1);

    // Youngest wins, r0 never matches
    step(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0);
    chk("young_sel", {28'd0, ex_fwd_sel}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("r0_sel", {28'd0, ex_fwd_sel}, 32'h0);

    // Flush during a load-use stall
    step(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd0, 1'b0);
    #2;
    chk("fl_pre_stall", {31'd0, stall}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd0, 1'b1);
    chk("fl_stall_drop", {31'd0, obs_stall}, 32'd0);
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd0, 1'b0);
    chk("fl_no_stall", {31'd0, obs_stall}, 32'd0);
    chk("fl_sel", {28'd0, ex_fwd_sel}, 32'h0);
    chk("fl_count", {16'd0, stall_count}, 32'd1);

    // Asynchronous reset mid-stall
    step(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd5, 1'b0);
    #2;
    chk("rs_pre_stall", {31'd0, stall}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rs_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rs_sel", {28'd0, ex_fwd_sel}, 32'd0);
    chk("rs_count", {16'd0, stall_count}, 32'd0);
    chk("rs_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b0);
    chk("rs_empty_stall", {31'd0, obs_stall}, 32'd0);
    chk("rs_empty_sel", {28'd0, ex_fwd_sel}, 32'd0);

    // Randomized traffic on a small register set to provoke frequent matches
    for (int t = 0; t < 2000; t++) begin
      step(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Deep instance: 19-cycle load-use stall against a 4-bit saturating counter
    chk("deep_count0", {28'd0, b_count}, 32'd0);
    b_valid = 1'b1; b_wr = 1'b1; b_ld = 1'b1; b_dst = 5'd9; b_src = 10'd0;
    @(posedge clk);
    #1;
    b_ld = 1'b0; b_dst = 5'd10; b_src = {5'd0, 5'd9};
    nst = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (b_stall) nst++;
      else break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("deep_stall_cycles", nst, 32'd19);
    chk("deep_count_sat", {28'd0, b_count}, 32'd15);
    chk("deep_ex_valid", {31'd0, b_ex_valid}, 32'd1);
    chk("deep_sel", {27'd0, b_sel[4:0]}, 32'd20);
    b_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
